btn_input_port: RTL and testbench

- Memory-mapped button input peripheral that the CPU polls.
- It is the input-side counterpart to the LED output path.
- It takes the raw asynchronous btn[6:0] pins and runs them through a 2-flop synchronizer, a per-button debounce counter and edge detection.
- It keeps sticky press/release event flags that the CPU reads and clears over the same simple single-cycle bus used by the data RAM.

---
 rtl/btn_input_port_pkg.sv | 17 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/btn_input_port.sv | 107 ++++++++++
 tb/tb_btn_input_port.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_input_port_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_input_port_pkg -- register addresses and 25 MHz debounce default
// Rev 1.0
// ---------------------------------------------------------------------------
package btn_input_port_pkg;

  localparam logic [1:0] BTN_ADDR_STATE   = 2'd0;
  localparam logic [1:0] BTN_ADDR_PRESS   = 2'd1;
  localparam logic [1:0] BTN_ADDR_RELEASE = 2'd2;
  localparam logic [1:0] BTN_ADDR_IRQMASK = 2'd3;

  // 10 ms of stable level at 25 MHz
  localparam int BTN_DEBOUNCE_25MHZ = 250000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce -- one button: 2-flop synchronizer, debounce counter, edge pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk_25mhz,
  input  logic reset_n,
  input  logic pin,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync_raw;
  logic          sync;
  logic [CW-1:0] count;
  logic          differ;
  logic          expire;

  assign sync   = sync_raw ^ ACTIVE_LOW;
  assign differ = (sync != state);
  assign expire = differ && (count == CNT_LAST);
  assign rise   = expire && sync;
  assign fall   = expire && !sync;

  // Synchronizer flops reset to the pin's idle level so no event fires after reset
  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      meta     <= ACTIVE_LOW;
      sync_raw <= ACTIVE_LOW;
      count    <= '0;
      state    <= 1'b0;
    end else begin
      meta     <= pin;
      sync_raw <= meta;
      if (!differ || expire) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (expire) begin
        state <= sync;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_input_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_input_port -- polled button peripheral with sticky press/release flags;
// define BTN_IRQ_EN to add the IRQ_MASK register and the irq output.  Rev 1.0
// ---------------------------------------------------------------------------
module btn_input_port
  import btn_input_port_pkg::*;
#(
  parameter int                 NUM_BTN         = 7,
  parameter int                 DEBOUNCE_CYCLES = BTN_DEBOUNCE_25MHZ,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = NUM_BTN'(7'b0000001)
) (
  input  logic               clk_25mhz,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [1:0]         address,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready
`ifdef BTN_IRQ_EN
  ,
  output logic               irq
`endif
);

  logic [NUM_BTN-1:0] state;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] press_evt;
  logic [NUM_BTN-1:0] release_evt;
  logic [NUM_BTN-1:0] clr_press;
  logic [NUM_BTN-1:0] clr_release;
  logic [NUM_BTN-1:0] reg_val;
  logic               unused_bits;

  assign unused_bits = ^write_data[31:NUM_BTN];

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
      ) u_debounce (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .pin       (btn[i]),
        .state     (state[i]),
        .rise      (rise[i]),
        .fall      (fall[i])
      );
    end
  endgenerate

  assign clr_press   = (write_en && address == BTN_ADDR_PRESS)   ? write_data[NUM_BTN-1:0] : '0;
  assign clr_release = (write_en && address == BTN_ADDR_RELEASE) ? write_data[NUM_BTN-1:0] : '0;

`ifdef BTN_IRQ_EN
  logic [NUM_BTN-1:0] irq_mask;

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (write_en && address == BTN_ADDR_IRQMASK) begin
        irq_mask <= write_data[NUM_BTN-1:0];
      end
      irq <= |((press_evt | release_evt) & irq_mask);
    end
  end
`endif

  always_comb begin
    reg_val = '0;
    case (address)
      BTN_ADDR_STATE:   reg_val = state;
      BTN_ADDR_PRESS:   reg_val = press_evt;
      BTN_ADDR_RELEASE: reg_val = release_evt;
`ifdef BTN_IRQ_EN
      BTN_ADDR_IRQMASK: reg_val = irq_mask;
`else
      BTN_ADDR_IRQMASK: reg_val = '0;
`endif
    endcase
  end

  // New edges are OR'd in after the clear so a same-cycle event survives W1C
  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      press_evt   <= '0;
      release_evt <= '0;
      read_data   <= '0;
      ready       <= 1'b0;
    end else begin
      press_evt   <= (press_evt & ~clr_press) | rise;
      release_evt <= (release_evt & ~clr_release) | fall;
      ready       <= read_en | write_en;
      if (read_en) begin
        read_data <= {{(32-NUM_BTN){1'b0}}, reg_val};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_input_port.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_input_port -- directed scenarios plus randomized run against a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_btn_input_port;
  import btn_input_port_pkg::*;

  localparam int             NB   = 7;
  localparam int             DEB  = 4;
  localparam logic [NB-1:0]  ALM  = 7'b0000001;
  localparam logic [NB-1:0]  IDLE = 7'b0000001;
`ifdef BTN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk_25mhz = 1'b0;
  logic          reset_n   = 1'b0;
  logic [NB-1:0] btn       = IDLE;
  logic [1:0]    address   = 2'd0;
  logic          read_en   = 1'b0;
  logic          write_en  = 1'b0;
  logic [31:0]   write_data = 32'd0;
  logic [31:0]   read_data;
  logic          ready;
`ifdef BTN_IRQ_EN
  logic          irq;
`endif

  int errors = 0;
  int checks = 0;

  always #20 clk_25mhz = ~clk_25mhz;

  btn_input_port #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW_MASK (ALM)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset_n    (reset_n),
    .btn        (btn),
    .address    (address),
    .read_en    (read_en),
    .write_en   (write_en),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready)
`ifdef BTN_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Reference model: a level is accepted once the synchronized (2-clock delayed)
  // pressed-level has differed from the accepted state for DEB consecutive samples.
  logic [NB-1:0] hist [0:DEB];
  logic [NB-1:0] m_state, m_press, m_release, m_mask;
  logic          m_irq, m_ready;
  logic [31:0]   m_rdata;

  always @(posedge clk_25mhz) begin
    logic [NB-1:0] rise_m, fall_m, sel, clr_p, clr_r;
    logic          steady;
    if (!reset_n) begin
      for (int k = 0; k <= DEB; k++) hist[k] = '0;
      m_state = '0; m_press = '0; m_release = '0; m_mask = '0;
      m_irq = 1'b0; m_ready = 1'b0; m_rdata = '0;
    end else begin
      rise_m = '0;
      fall_m = '0;
      for (int b = 0; b < NB; b++) begin
        steady = 1'b1;
        for (int k = 1; k <= DEB; k++) if (hist[k][b] == m_state[b]) steady = 1'b0;
        if (steady) begin
          if (m_state[b]) fall_m[b] = 1'b1;
          else            rise_m[b] = 1'b1;
        end
      end
      case (address)
        BTN_ADDR_STATE:   sel = m_state;
        BTN_ADDR_PRESS:   sel = m_press;
        BTN_ADDR_RELEASE: sel = m_release;
        default:          sel = m_mask;
      endcase
      m_ready = read_en | write_en;
      if (read_en) m_rdata = {25'd0, sel};
      m_irq = IRQ_ON && (|((m_press | m_release) & m_mask));
      clr_p = (write_en && address == BTN_ADDR_PRESS)   ? write_data[NB-1:0] : '0;
      clr_r = (write_en && address == BTN_ADDR_RELEASE) ? write_data[NB-1:0] : '0;
      m_press   = (m_press & ~clr_p) | rise_m;
      m_release = (m_release & ~clr_r) | fall_m;
      if (IRQ_ON && write_en && address == BTN_ADDR_IRQMASK) m_mask = write_data[NB-1:0];
      m_state = m_state ^ (rise_m | fall_m);
    end
    for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = reset_n ? (btn ^ ALM) : '0;
  end

  // Drive bus inputs for one clock; called and returns on a falling edge
  task automatic tick(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd);
    read_en = rd; write_en = wr; address = a; write_data = wd;
    @(negedge clk_25mhz);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; btn = IDLE;
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b1;
    checks++;
    if (ready !== 1'b0 || read_data !== 32'd0) begin
      errors++; $display("FAIL reset_out: ready=%b read_data=%h required 0/0", ready, read_data);
    end
    for (int a = 0; a < 4; a++) begin
      tick(1'b1, 1'b0, 2'(a), 32'd0);
      checks++;
      if (ready !== 1'b1 || read_data !== 32'd0) begin
        errors++; $display("FAIL reset_read[%0d]: ready=%b data=%h required 1/0", a, ready, read_data);
      end
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      checks++;
      if (ready !== 1'b0) begin
        errors++; $display("FAIL ready_pulse[%0d]: ready=%b required 0", a, ready);
      end
    end
`ifdef BTN_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b required 0", irq); end
`endif
  endtask

  task automatic test_press;
    btn = 7'b0101100;
    repeat (5) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b1, 1'b0, BTN_ADDR_STATE, 32'd0);
    checks++;
    if (read_data !== 32'd0) begin
      errors++; $display("FAIL latency_early: data=%h required 0", read_data);
    end
    tick(1'b1, 1'b0, BTN_ADDR_STATE, 32'd0);
    checks++;
    if (read_data !== 32'h2D) begin
      errors++; $display("FAIL press_state: data=%h required 2d", read_data);
    end
    tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
    checks++;
    if (read_data !== 32'h2D) begin
      errors++; $display("FAIL press_evt: data=%h required 2d", read_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] want [0:5];
    want[0] = 32'h2D; want[1] = 32'h2D; want[2] = 32'h2D;
    want[3] = 32'h25; want[4] = 32'h25; want[5] = 32'h00;
    tick(1'b1, 1'b0, BTN_ADDR_STATE,   32'd0);
    tick(1'b1, 1'b0, BTN_ADDR_PRESS,   32'd0);
    tick(1'b1, 1'b1, BTN_ADDR_PRESS,   32'h0000_0008);
    tick(1'b1, 1'b0, BTN_ADDR_PRESS,   32'd0);
    tick(1'b0, 1'b1, BTN_ADDR_PRESS,   32'hFFFF_FFFF);
    tick(1'b1, 1'b0, BTN_ADDR_PRESS,   32'd0);
    checks++;
    if (ready !== 1'b1 || read_data !== want[5]) begin
      errors++; $display("FAIL b2b_clear: ready=%b data=%h required 1/%h", ready, read_data, want[5]);
    end
    // Re-run the same sequence with per-cycle checking of data and ready
    btn = IDLE; repeat (8) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b1, BTN_ADDR_RELEASE, 32'hFFFF_FFFF);
    btn = 7'b0101100; repeat (8) tick(1'b0, 1'b0, 2'd0, 32'd0);
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: tick(1'b1, 1'b0, BTN_ADDR_STATE, 32'd0);
        1: tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
        2: tick(1'b1, 1'b1, BTN_ADDR_PRESS, 32'h0000_0008);
        3: tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
        default: tick(1'b0, 1'b1, BTN_ADDR_PRESS, 32'hFFFF_FFFF);
      endcase
      checks++;
      if (ready !== 1'b1 || read_data !== want[s]) begin
        errors++; $display("FAIL b2b[%0d]: ready=%b data=%h required 1/%h", s, ready, read_data, want[s]);
      end
    end
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready=%b required 0", ready); end
  endtask

  task automatic test_glitch;
    btn = IDLE;
    repeat (8) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b1, BTN_ADDR_PRESS,   32'hFFFF_FFFF);
    tick(1'b0, 1'b1, BTN_ADDR_RELEASE, 32'hFFFF_FFFF);
    btn[3] = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 2'd0, 32'd0);
    btn[3] = 1'b0;
    repeat (8) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b1, 1'b0, BTN_ADDR_STATE, 32'd0);
    checks++;
    if (read_data !== 32'd0) begin errors++; $display("FAIL glitch_state: data=%h required 0", read_data); end
    tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
    checks++;
    if (read_data !== 32'd0) begin errors++; $display("FAIL glitch_press: data=%h required 0", read_data); end
  endtask

  task automatic test_collision;
    btn = IDLE | 7'b0000100;
    repeat (8) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
    checks++;
    if (read_data !== 32'h04) begin errors++; $display("FAIL coll_setup: data=%h required 04", read_data); end
    btn = IDLE;
    repeat (5) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b1, BTN_ADDR_PRESS, 32'h04);
    tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
    checks++;
    if (read_data !== 32'd0) begin errors++; $display("FAIL coll_press_clr: data=%h required 0", read_data); end
    tick(1'b1, 1'b0, BTN_ADDR_RELEASE, 32'd0);
    checks++;
    if (read_data !== 32'h04) begin errors++; $display("FAIL coll_release: data=%h required 04", read_data); end
    btn = IDLE | 7'b0000100;
    repeat (5) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b1, BTN_ADDR_PRESS, 32'h04);
    tick(1'b1, 1'b0, BTN_ADDR_PRESS, 32'd0);
    checks++;
    if (read_data !== 32'h04) begin errors++; $display("FAIL coll_set_wins: data=%h required 04", read_data); end
  endtask

  task automatic test_irq;
    tick(1'b0, 1'b1, BTN_ADDR_PRESS,   32'hFFFF_FFFF);
    tick(1'b0, 1'b1, BTN_ADDR_RELEASE, 32'hFFFF_FFFF);
    tick(1'b0, 1'b1, BTN_ADDR_IRQMASK, 32'hFFFF_FF40);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL mask_wr_ack: ready=%b required 1", ready); end
    tick(1'b1, 1'b0, BTN_ADDR_IRQMASK, 32'd0);
    checks++;
    if (read_data !== (IRQ_ON ? 32'h40 : 32'h0)) begin
      errors++; $display("FAIL mask_read: data=%h required %h", read_data, IRQ_ON ? 32'h40 : 32'h0);
    end
`ifdef BTN_IRQ_EN
    btn[6] = 1'b1;
    repeat (6) tick(1'b0, 1'b0, 2'd0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: irq=%b required 0", irq); end
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b required 1", irq); end
    tick(1'b0, 1'b1, BTN_ADDR_PRESS, 32'h40);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: irq=%b required 1", irq); end
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b required 0", irq); end
    btn[5] = 1'b1;
    repeat (10) tick(1'b0, 1'b0, 2'd0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked: irq=%b required 0", irq); end
`endif
  endtask

  task automatic test_reset_mid;
    btn = IDLE;
    repeat (8) tick(1'b0, 1'b0, 2'd0, 32'd0);
    btn[1] = 1'b1;
    repeat (4) tick(1'b0, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b0;
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b1;
    checks++;
    if (ready !== 1'b0 || read_data !== 32'd0) begin
      errors++; $display("FAIL mid_reset_out: ready=%b data=%h required 0/0", ready, read_data);
    end
`ifdef BTN_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: irq=%b required 0", irq); end
`endif
    for (int a = 0; a < 4; a++) begin
      tick(1'b1, 1'b0, 2'(a), 32'd0);
      checks++;
      if (read_data !== 32'd0) begin
        errors++; $display("FAIL mid_reset_reg[%0d]: data=%h required 0", a, read_data);
      end
    end
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b1, 1'b0, BTN_ADDR_STATE, 32'd0);
    checks++;
    if (read_data !== 32'd0) begin errors++; $display("FAIL mid_restart_early: data=%h required 0", read_data); end
    tick(1'b1, 1'b0, BTN_ADDR_STATE, 32'd0);
    checks++;
    if (read_data !== 32'h02) begin errors++; $display("FAIL mid_restart: data=%h required 02", read_data); end
  endtask

  task automatic test_random;
    int hold = 0;
    for (int c = 0; c < 500; c++) begin
      if (hold == 0) begin
        btn  = NB'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      reset_n = ($urandom_range(0, 149) != 0);
      tick(1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), $urandom);
      checks++;
      if (ready !== m_ready || read_data !== m_rdata) begin
        errors++; $display("FAIL rand[%0d]: ready=%b data=%h required %b/%h", c, ready, read_data, m_ready, m_rdata);
      end
`ifdef BTN_IRQ_EN
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: irq=%b required %b", c, irq, m_irq); end
`endif
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk_25mhz);
    test_reset;
    test_press;
    test_back_to_back;
    test_glitch;
    test_collision;
    test_irq;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
